cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shares a single word-wide RAM port between two cache requesters: port 0 is the instruction cache and port 1 is the data cache. It arbitrates round-robin between them. A line-fill read is serialised into BLOCK_SIZE single-word RAM reads and the words are assembled into one block. A write-through store is forwarded as a single RAM write. Each completed transaction is returned to the granted cache as a one-cycle `resp_valid` pulse, with the assembled block on the shared `resp_data` bus that feeds the cache's `ram_data` input.

## Interface
- RAM_ADDRESS_BITS, 10, word address width.
- DATA_BITS, 32, word width.
- BLOCK_BITS, 2, offset bits; BLOCK_SIZE = 2**BLOCK_BITS words per line.
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- req_read_en  in  [1:0]  per-port line-fill request, held level.
- req_write_en  in  [1:0]  per-port single-word write request, held level.
- req_address  in  [1:0][RAM_ADDRESS_BITS]  per-port word address.
- req_write_data  in  [1:0][DATA_BITS]  per-port store data.
- resp_valid  out  [1:0]  one-cycle completion pulse, one-hot to the granted port.
- resp_data  out  [BLOCK_SIZE][DATA_BITS]  assembled line, shared by both ports; word k sits at index k.
- busy  out  1  high whenever the state is not IDLE.
- ram_address  out  RAM_ADDRESS_BITS  RAM word address.
- ram_read_en  out  1  one-cycle read strobe.
- ram_write_en  out  1  one-cycle write strobe.
- ram_write_data  out  DATA_BITS  RAM write data.
- ram_rdata  in  DATA_BITS  RAM read data.
- ram_rvalid  in  1  RAM read data valid.

## Operation
- FSM states: IDLE, READ_ISSUE, READ_WAIT, WRITE, RESPOND.
- **IDLE.** A port is pending if its `req_read_en` or `req_write_en` is high.
  - If both ports are pending, the port not granted last wins.
  - The `last_grant` register resets to 1, so port 0 wins the first tie.
  - On grant, the port's address, write data and operation are captured into registers. Later changes on the request inputs are ignored until RESPOND.
  - A port with both enables high is served as a WRITE.
- **READ path.**
  - Base address = captured address with the low BLOCK_BITS bits cleared. The word counter k resets to 0.
  - READ_ISSUE: drive `ram_read_en`=1 and `ram_address`={base[high bits], k}, then go to READ_WAIT.
  - READ_WAIT: hold until `ram_rvalid`=1, then store `ram_rdata` into line[k].
    - If k == BLOCK_SIZE-1, go to RESPOND.
    - Otherwise increment k and return to READ_ISSUE.
  - Exactly one RAM read is outstanding at any time.
- **WRITE path.** Drive `ram_write_en`=1 with the captured full address and data for one cycle, then go to RESPOND. The write is not block-aligned.
- **RESPOND.**
  - Set `resp_valid`[grant]=1 for one cycle.
  - `resp_data` shows the line register. After a write, `resp_data` is the stale line and is not meaningful.
  - Update `last_grant`, then go to IDLE.
- **Requester rule.** The requester deasserts its request in the cycle after `resp_valid`. A request still high when the FSM next reaches IDLE is treated as a new request.
- `ram_rvalid` is ignored outside READ_WAIT.
- The `resp_data` line register holds its value between transactions. It is overwritten word by word during a fill.

## Timing
- Reset values: every output is 0 and `resp_data` is all 0.
  - Internal state: FSM in IDLE, k=0, `last_grant`=1.
- Reset mid-transaction: the FSM returns to IDLE at the reset edge and all RAM strobes are low in the next cycle.
  - The partial line is discarded and no `resp_valid` is issued.
  - Any `ram_rvalid` arriving after reset is ignored.
- Read latency, counted from the grant edge E0:
  - Word k is issued in the cycle after edge E(2k).
  - With RAM latency 1, `resp_valid` is high in the cycle after edge E(2·BLOCK_SIZE), which is E8 for the default parameters.
  - Each extra RAM wait cycle adds one cycle per word.
- Write latency: `ram_write_en` is high in the cycle after E0 and `resp_valid` is high in the cycle after E1.
- Minimum gap between two grants is one IDLE cycle.
- `busy` reflects the registered state.

## Structure
- Package `cache_pkg` holds:
  - the BLOCK_SIZE function of BLOCK_BITS;
  - the `arb_state_t` enum;
  - the `cache_line_t` typedef, an array of BLOCK_SIZE words of DATA_BITS.
- Sub-module `rr_arbiter2` takes `pending[1:0]` and `last_grant` and produces the grant index and a grant-valid flag. It is purely combinational.
- Everything else sits in one FSM plus its datapath registers.

## Test plan
- **Single fill.** Port 0 reads address 0x2B; the RAM returns addr+0x100 with latency 1.
  - Required: RAM reads at 0x28, 0x29, 0x2A, 0x2B in that order.
  - `resp_data` = {0x128, 0x129, 0x12A, 0x12B} with `resp_valid`=01 eight cycles after the grant edge.
- **Single write.** Port 1 writes 0xDEADBEEF to 0x3F.
  - Required: one `ram_write_en` cycle with that address and data, then `resp_valid`=10 on the next cycle.
- **Contention.** Both ports request in the same cycle out of reset.
  - Required: port 0 is served first, then port 1.
  - Then both request again: port 0 is served first again, because `last_grant` was 1.
  - A port 1 request that was continuously pending during port 0's service is served next.
- **Stretched RAM.** `ram_rvalid` is delayed 3 cycles per word.
  - Required: strobes stay single-cycle and words are captured in the correct slots.
  - A spurious `ram_rvalid` during READ_ISSUE or IDLE has no effect.
- **Reset mid-fill.** Assert reset after word 1 of a fill.
  - Required: all outputs are 0 on the next cycle and there is no `resp_valid`.
  - The next request is served normally from k=0.
- **Request change after grant.** Change `req_address` and `req_write_data` after the grant.
  - Required: the RAM still sees the captured values.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the cache/RAM arbiter: line geometry, FSM states and the line type.
package cache_pkg;

    localparam int DEF_RAM_ADDRESS_BITS = 10;
    localparam int DEF_DATA_BITS        = 32;
    localparam int DEF_BLOCK_BITS       = 2;

    function automatic int block_size(input int block_bits);
        return 1 << block_bits;
    endfunction

    localparam int DEF_BLOCK_SIZE = block_size(DEF_BLOCK_BITS);

    typedef enum logic [2:0] {
        IDLE,
        READ_ISSUE,
        READ_WAIT,
        WRITE,
        RESPOND
    } arb_state_t;

    typedef logic [DEF_BLOCK_SIZE-1:0][DEF_DATA_BITS-1:0] cache_line_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] pending,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |pending;
        grant       = 1'b0;
        case (pending)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one word-wide RAM port between the I-cache (port 0) and D-cache (port 1):
// line fills are serialised into single-word reads, stores pass through as one write.
//
// state      | meaning
// IDLE       | no transaction; arbitrate and capture the winning request
// READ_ISSUE | strobe ram_read_en for word k of the line
// READ_WAIT  | wait for ram_rvalid, store word k
// WRITE      | strobe ram_write_en with captured address/data
// RESPOND    | one-cycle resp_valid to the granted port
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int RAM_ADDRESS_BITS = DEF_RAM_ADDRESS_BITS,
    parameter int DATA_BITS        = DEF_DATA_BITS,
    parameter int BLOCK_BITS       = DEF_BLOCK_BITS
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic [1:0]                                          req_read_en,
    input  logic [1:0]                                          req_write_en,
    input  logic [1:0][RAM_ADDRESS_BITS-1:0]                    req_address,
    input  logic [1:0][DATA_BITS-1:0]                           req_write_data,
    output logic [1:0]                                          resp_valid,
    output logic [block_size(BLOCK_BITS)-1:0][DATA_BITS-1:0]    resp_data,
    output logic                                                busy,
    output logic [RAM_ADDRESS_BITS-1:0]                         ram_address,
    output logic                                                ram_read_en,
    output logic                                                ram_write_en,
    output logic [DATA_BITS-1:0]                                ram_write_data,
    input  logic [DATA_BITS-1:0]                                ram_rdata,
    input  logic                                                ram_rvalid
);

    localparam int BLOCK_SIZE = block_size(BLOCK_BITS);
    localparam logic [BLOCK_BITS-1:0] LAST_WORD = BLOCK_BITS'(BLOCK_SIZE - 1);

    arb_state_t                              state_q, state_d;
    logic [BLOCK_BITS-1:0]                   k_q, k_d;
    logic                                    last_grant_q, last_grant_d;
    logic                                    grant_q, grant_d;
    logic                                    is_write_q, is_write_d;
    logic [RAM_ADDRESS_BITS-1:0]             addr_q, addr_d;
    logic [DATA_BITS-1:0]                    wdata_q, wdata_d;
    logic [BLOCK_SIZE-1:0][DATA_BITS-1:0]    line_q, line_d;

    logic [1:0] pending;
    logic       arb_grant;
    logic       arb_valid;

    assign pending = req_read_en | req_write_en;

    rr_arbiter2 u_rr_arbiter2 (
        .pending     (pending),
        .last_grant  (last_grant_q),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        last_grant_d   = last_grant_q;
        grant_d        = grant_q;
        is_write_d     = is_write_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        line_d         = line_q;
        resp_valid     = 2'b00;
        ram_address    = '0;
        ram_read_en    = 1'b0;
        ram_write_en   = 1'b0;
        ram_write_data = '0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d    = arb_grant;
                    addr_d     = req_address[arb_grant];
                    wdata_d    = req_write_data[arb_grant];
                    // write enable dominates when a port raises both
                    is_write_d = req_write_en[arb_grant];
                    k_d        = '0;
                    state_d    = req_write_en[arb_grant] ? WRITE : READ_ISSUE;
                end
            end
            READ_ISSUE: begin
                ram_read_en = 1'b1;
                ram_address = {addr_q[RAM_ADDRESS_BITS-1:BLOCK_BITS], k_q};
                state_d     = READ_WAIT;
            end
            READ_WAIT: begin
                if (ram_rvalid) begin
                    line_d[k_q] = ram_rdata;
                    if (k_q == LAST_WORD) begin
                        state_d = RESPOND;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = READ_ISSUE;
                    end
                end
            end
            WRITE: begin
                ram_write_en   = 1'b1;
                ram_address    = addr_q;
                ram_write_data = wdata_q;
                state_d        = RESPOND;
            end
            RESPOND: begin
                resp_valid[grant_q] = 1'b1;
                last_grant_d        = grant_q;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            is_write_q   <= is_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            line_q       <= line_d;
        end
    end

    assign resp_data = line_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: a transaction-level model predicts RAM
// accesses and responses; monitors compare them as the DUT produces them.
module tb_cache_mem_arbiter;
    import cache_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BB = 2;
    localparam int BS = 1 << BB;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [1:0]               req_read_en = '0;
    logic [1:0]               req_write_en = '0;
    logic [1:0][AW-1:0]       req_address = '0;
    logic [1:0][DW-1:0]       req_write_data = '0;
    logic [1:0]               resp_valid;
    logic [BS-1:0][DW-1:0]    resp_data;
    logic                     busy;
    logic [AW-1:0]            ram_address;
    logic                     ram_read_en;
    logic                     ram_write_en;
    logic [DW-1:0]            ram_write_data;
    logic [DW-1:0]            ram_rdata;
    logic                     ram_rvalid;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .RAM_ADDRESS_BITS (AW),
        .DATA_BITS        (DW),
        .BLOCK_BITS       (BB)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_read_en    (req_read_en),
        .req_write_en   (req_write_en),
        .req_address    (req_address),
        .req_write_data (req_write_data),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .busy           (busy),
        .ram_address    (ram_address),
        .ram_read_en    (ram_read_en),
        .ram_write_en   (ram_write_en),
        .ram_write_data (ram_write_data),
        .ram_rdata      (ram_rdata),
        .ram_rvalid     (ram_rvalid)
    );

    typedef struct {
        bit            is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ram_op_t;

    typedef struct {
        int          port;
        bit          is_read;
        cache_line_t line;
        int          cyc;
    } resp_t;

    ram_op_t       exp_ram[$];
    resp_t         exp_resp[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            lat = 1;
    bit            spur = 1'b0;
    logic [DW-1:0] salt = '0;
    bit            lg_model = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (32'(a) + 32'h100) ^ salt;
    endfunction

    task automatic check(input bit ok, input string name, input string act, input string req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, act, req);
    endtask

    // RAM model: answers each read after 'lat' cycles, optionally injects junk rvalid
    initial begin
        int            cnt;
        logic [AW-1:0] ra;
        cnt = 0;
        ra = '0;
        ram_rvalid = 1'b0;
        ram_rdata = '0;
        forever begin
            @(negedge clk);
            ram_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ram_rvalid = 1'b1;
                    ram_rdata = mem_word(ra);
                end
            end
            if (reset_n && ram_read_en) begin
                ra = ram_address;
                cnt = lat;
            end
            if (spur && !ram_rvalid && (ram_read_en || !busy) && $urandom_range(1, 0) == 1) begin
                ram_rvalid = 1'b1;
                ram_rdata = $urandom;
            end
        end
    end

    // Monitor: compares RAM strobes and responses against the scoreboard queues
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (ram_read_en || ram_write_en) begin
                    if (exp_ram.size() == 0) begin
                        check(1'b0, "ram_unexpected",
                              $sformatf("rd=%0b wr=%0b addr=%h", ram_read_en, ram_write_en, ram_address),
                              "no strobe");
                    end else begin
                        ram_op_t e;
                        e = exp_ram.pop_front();
                        check(ram_write_en == e.is_write && ram_read_en == !e.is_write &&
                              ram_address == e.addr && (!e.is_write || ram_write_data == e.data),
                              "ram_op",
                              $sformatf("rd=%0b wr=%0b addr=%h data=%h", ram_read_en, ram_write_en,
                                        ram_address, ram_write_data),
                              $sformatf("wr=%0b addr=%h data=%h", e.is_write, e.addr, e.data));
                    end
                end
                if (resp_valid != 2'b00) begin
                    if (exp_resp.size() == 0) begin
                        check(1'b0, "resp_unexpected", $sformatf("resp_valid=%b", resp_valid), "none");
                    end else begin
                        resp_t      r;
                        logic [1:0] ev;
                        r = exp_resp.pop_front();
                        ev = 2'(1 << r.port);
                        check(resp_valid == ev, "resp_port",
                              $sformatf("%b", resp_valid), $sformatf("%b", ev));
                        if (r.is_read)
                            check(resp_data == r.line, "resp_line",
                                  $sformatf("%h", resp_data), $sformatf("%h", r.line));
                        check(cyc == r.cyc, "resp_cycle",
                              $sformatf("%0d", cyc), $sformatf("%0d", r.cyc));
                    end
                    if (resp_valid[0]) begin
                        req_read_en[0] = 1'b0;
                        req_write_en[0] = 1'b0;
                    end
                    if (resp_valid[1]) begin
                        req_read_en[1] = 1'b0;
                        req_write_en[1] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check_idle(input string name);
        check(busy == 1'b0 && resp_valid == 2'b00, {name, "_ctl"},
              $sformatf("busy=%b resp_valid=%b", busy, resp_valid), "busy=0 resp_valid=00");
        check(!ram_read_en && !ram_write_en && ram_address == '0 && ram_write_data == '0, {name, "_ram"},
              $sformatf("rd=%b wr=%b addr=%h wdata=%h", ram_read_en, ram_write_en, ram_address, ram_write_data),
              "all zero");
        check(resp_data == '0, {name, "_line"}, $sformatf("%h", resp_data), "0");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req_read_en = '0;
        req_write_en = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset_n = 1'b1;
        lg_model = 1'b1;
        exp_ram.delete();
        exp_resp.delete();
    endtask

    // Issues one or two requests together and predicts order, RAM traffic and timing
    task automatic run_phase(input bit [1:0] en, input bit [1:0] wr,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input bit scramble);
        logic [1:0][AW-1:0] a;
        logic [1:0][DW-1:0] d;
        int                 order[$];
        int                 c;
        int                 t;
        int                 r_prev;
        a = {a1, a0};
        d = {d1, d0};
        @(negedge clk);
        c = cyc;
        if (en == 2'b11) begin
            order.push_back(lg_model ? 0 : 1);
            order.push_back(lg_model ? 1 : 0);
        end else begin
            order.push_back(en[1] ? 1 : 0);
        end
        r_prev = c - 1;
        foreach (order[j]) begin
            int            p;
            int            dur;
            resp_t         r;
            logic [AW-1:0] base;
            p = order[j];
            r.port = p;
            r.line = '0;
            if (wr[p]) begin
                exp_ram.push_back('{1'b1, a[p], d[p]});
                r.is_read = 1'b0;
                dur = 2;
            end else begin
                base = a[p] & ~AW'(BS - 1);
                for (int k = 0; k < BS; k++) begin
                    exp_ram.push_back('{1'b0, base + AW'(k), '0});
                    r.line[k] = mem_word(base + AW'(k));
                end
                r.is_read = 1'b1;
                dur = 1 + BS * (1 + lat);
            end
            r.cyc = r_prev + 1 + dur;
            r_prev = r.cyc;
            exp_resp.push_back(r);
            lg_model = (p == 1);
        end
        for (int i = 0; i < 2; i++) begin
            if (en[i]) begin
                req_address[i] = a[i];
                req_write_data[i] = d[i];
                req_write_en[i] = wr[i];
                req_read_en[i] = wr[i] ? 1'($urandom_range(1, 0)) : 1'b1;
            end
        end
        if (scramble) begin
            t = 0;
            while (!busy && t < 50) begin
                @(negedge clk);
                t++;
            end
            req_address[order[0]] = AW'($urandom);
            req_write_data[order[0]] = $urandom;
        end
        t = 0;
        while (exp_resp.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_resp.size() != 0) begin
            check(1'b0, "phase_timeout", $sformatf("%0d responses outstanding", exp_resp.size()), "0");
            exp_resp.delete();
            req_read_en = '0;
            req_write_en = '0;
        end
        repeat (2) @(negedge clk);
        check(exp_ram.size() == 0, "ram_ops_drained", $sformatf("%0d missing", exp_ram.size()), "0");
        exp_ram.delete();
    endtask

    task automatic reset_mid_fill();
        int c;
        lat = 1;
        spur = 1'b0;
        @(negedge clk);
        c = cyc;
        for (int k = 0; k < 3; k++) exp_ram.push_back('{1'b0, AW'(10'h150 + k), '0});
        req_address[0] = 10'h152;
        req_read_en[0] = 1'b1;
        while (cyc < c + 5) @(negedge clk);
        #1;
        reset_n = 1'b0;
        req_read_en = '0;
        req_write_en = '0;
        @(negedge clk);
        check_idle("midfill");
        reset_n = 1'b1;
        lg_model = 1'b1;
        check(exp_ram.size() == 0, "midfill_reads", $sformatf("%0d missing", exp_ram.size()), "0");
        exp_ram.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        do_reset();

        salt = '0;
        lat = 1;
        spur = 1'b0;
        run_phase(2'b01, 2'b00, 10'h2B, '0, '0, '0, 1'b0);
        run_phase(2'b10, 2'b10, '0, 10'h3F, '0, 32'hDEADBEEF, 1'b0);

        do_reset();
        run_phase(2'b11, 2'b00, 10'h101, 10'h2C6, '0, '0, 1'b0);
        run_phase(2'b11, 2'b01, 10'h07A, 10'h3F0, 32'h1234_5678, '0, 1'b0);

        lat = 4;
        spur = 1'b1;
        salt = 32'hA5A5_0000;
        run_phase(2'b01, 2'b00, 10'h1C5, '0, '0, '0, 1'b0);
        run_phase(2'b11, 2'b00, 10'h033, 10'h0E9, '0, '0, 1'b0);

        reset_mid_fill();
        lat = 1;
        spur = 1'b0;
        run_phase(2'b11, 2'b00, 10'h155, 10'h207, '0, '0, 1'b0);

        run_phase(2'b01, 2'b00, 10'h09D, '0, '0, '0, 1'b1);
        run_phase(2'b10, 2'b10, '0, 10'h211, '0, 32'hCAFE_F00D, 1'b1);

        for (int n = 0; n < 40; n++) begin
            lat = $urandom_range(3, 1);
            spur = 1'($urandom_range(1, 0));
            salt = $urandom;
            run_phase(2'($urandom_range(3, 1)), 2'($urandom_range(3, 0)),
                      AW'($urandom), AW'($urandom), $urandom, $urandom,
                      1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
